absorb_stream: RTL and testbench
================================

Name: absorb_stream

Overview:
- Sequential, parametrised successor to the combinational absorb step.
- Owns the 1600-bit Keccak state for one message, accepts an AXI-Stream-style byte stream of width DWIDTH, and XORs bytes into the rate portion at arbitrary byte offsets.
- Buffers overflow bytes across block boundaries and applies FIPS 202 multi-rate padding with a per-mode domain suffix.
- Hands off to the permutation engine through a start/done handshake. Sits between the input stream interface and keccak_f permutation core.

Parameters:
- DWIDTH, 256, stream data width in bits; legal values 64, 128, 256, 512.
- KEEP_W, DWIDTH/8, byte-enable width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  begin new message; sampled only in IDLE or DONE
- mode_i  in  3  0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256
- t_data_i  in  DWIDTH  message bytes, byte k at bits [8k+7:8k]
- t_keep_i  in  KEEP_W  byte enables, contiguous from bit 0
- t_valid_i  in  1  beat valid
- t_last_i  in  1  final beat of message
- t_ready_o  out  1  beat accepted when t_valid_i & t_ready_o
- perm_start_o  out  1  one-cycle pulse: state_o is ready to permute
- perm_done_i  in  1  one-cycle pulse: perm_state_i valid
- perm_state_i  in  5x5x64  permuted state, [x][y][z] packed
- state_o  out  5x5x64  current state register
- busy_o  out  1  high in every state except IDLE and DONE
- absorb_done_o  out  1  level, high in DONE

Behaviour:
- Reset (rst_n=0 at clk edge): FSM=IDLE; state, byte_cnt, carry regs cleared; all outputs 0. Reset is honoured in any state, including mid-permutation; a later perm_done_i is ignored while in IDLE.
- Rate in bytes by mode: 144, 136, 104, 72, 168, 136. Suffix byte: 0x06 for SHA3, 0x1F for SHAKE.
- start_i with mode_i>5 is ignored.
- Byte mapping: block byte b goes to lane L=b/8, x=L%5, y=L/5, bits [(b%8)*8 +: 8].
- Only the final beat may have partial keep; keep=0 is legal only with t_last_i.
- IDLE / DONE: t_ready_o=0.
  - start_i: latch mode, rate and suffix; clear state, byte_cnt=0, carry=0; go to ABSORB.
  - absorb_done_o is cleared on leaving DONE.
- ABSORB: t_ready_o = ~carry_valid. For an accepted beat, n=popcount(keep), room=rate-byte_cnt:
  - n<room: XOR n bytes at byte_cnt; byte_cnt+=n. If last, go to PAD.
  - n==room: XOR the bytes, then go to PERM_WAIT. Set pad_pending=t_last_i.
  - n>room: XOR the low room bytes; store the upper n-room bytes, right-aligned, in the carry reg; set carry_valid=1 and carry_last=t_last_i; go to PERM_WAIT.
- Carry drain: in the first ABSORB cycle after a permutation with carry_valid=1, XOR the carry at byte 0, byte_cnt=carry_len, clear carry_valid, and accept no beat that cycle. If carry_last, go to PAD next.
  - The carry always fits: carry_len ≤ KEEP_W-1 < 72.
- PERM_WAIT: perm_start_o pulses in the first cycle only. On perm_done_i: state←perm_state_i, byte_cnt=0, then:
  - pad_pending set: go to PAD at offset 0;
  - otherwise: go to ABSORB.
  - perm_done_i in any other state is ignored.
- PAD (1 cycle): byte[byte_cnt]^=suffix; byte[rate-1]^=0x80. When byte_cnt==rate-1, that byte receives suffix^0x80 (0x86 / 0x9F). Then go to FINAL_WAIT.
- FINAL_WAIT: perm_start_o pulses in the first cycle. On perm_done_i: state←perm_state_i, go to DONE.
- Latency:
  - accepted beat to state_o update: 1 cycle;
  - entry to PERM_WAIT to perm_start_o: same cycle as the state transition, registered.

Test Plan:
- SHA3-256, start then keep=0 with last: PAD gives lane[0][0]=0x06 and lane[1][3]=0x8000000000000000. One perm_start_o pulse, then absorb_done_o after perm_done_i.
- SHA3-512, DWIDTH=256, three full beats (96 bytes, last on the third):
  - third beat: room 8, carry 24 bytes, perm_start_o pulses;
  - after done: carry lands at bytes 0–23, suffix at byte 24, 0x80 at byte 71;
  - exactly two permutations total.
- SHA3-512, DWIDTH=256, beats keep=all, then keep=0xFF with last (72 bytes): first perm covers the full block; second block has lane[0][0]=0x06 and lane[3][1]=0x8000000000000000.
- SHAKE128, 167-byte message: suffix and pad share byte 167, so lane[0][4] top byte = 0x9F.
- Backpressure: t_valid_i held high during PERM_WAIT and the carry-drain cycle. t_ready_o must be 0 and no beat may be lost or duplicated; compare the final state against a golden model.
- Reset mid-PERM_WAIT, then a stray perm_done_i: outputs return to 0, FSM stays in IDLE, and a new start_i proceeds normally.

Source files
------------

// File: rtl/absorb_stream.sv
// rtl/absorb_stream.sv - Keccak sponge absorb stage: byte-stream XOR into rate, carry across blocks, padding, permutation handshake
module absorb_stream #(
    parameter int DWIDTH = 256,
    localparam int KEEP_W = DWIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [2:0]               mode_i,
    input  logic [DWIDTH-1:0]        t_data_i,
    input  logic [KEEP_W-1:0]        t_keep_i,
    input  logic                     t_valid_i,
    input  logic                     t_last_i,
    output logic                     t_ready_o,
    output logic                     perm_start_o,
    input  logic                     perm_done_i,
    input  logic [4:0][4:0][63:0]    perm_state_i,
    output logic [4:0][4:0][63:0]    state_o,
    output logic                     busy_o,
    output logic                     absorb_done_o
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ABSORB     = 3'd1;
    localparam logic [2:0] S_PERM_WAIT  = 3'd2;
    localparam logic [2:0] S_PAD        = 3'd3;
    localparam logic [2:0] S_FINAL_WAIT = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    // Widest rate (SHAKE128) is 168 bytes; all block-relative vectors use this width.
    localparam int RW = 1344;

    logic [2:0]        fsm;
    logic [1599:0]     st;
    logic [1599:0]     perm_flat;
    logic [7:0]        byte_cnt;
    logic [7:0]        rate;
    logic [7:0]        suffix;
    logic [DWIDTH-1:0] carry;
    logic [7:0]        carry_len;
    logic              carry_valid;
    logic              carry_last;
    logic              pad_pending;

    logic [7:0]        rate_sel;
    logic [7:0]        sfx_sel;
    logic [7:0]        n_bytes;
    logic [7:0]        room;
    logic [7:0]        n_take;
    logic [7:0]        rate_m1;
    logic [DWIDTH-1:0] data_kept;
    logic [DWIDTH-1:0] data_take;
    logic [DWIDTH-1:0] carry_next;
    logic [RW-1:0]     beat_vec;
    logic [RW-1:0]     pad_vec;
    logic [RW-1:0]     carry_vec;
    logic              beat;

    // Internal state is kept in lane order (lane L = 5y+x at bits [64L +: 64]).
    for (genvar gx = 0; gx < 5; gx++) begin : g_x
        for (genvar gy = 0; gy < 5; gy++) begin : g_y
            assign state_o[gx][gy]                     = st[64*(5*gy+gx) +: 64];
            assign perm_flat[64*(5*gy+gx) +: 64]       = perm_state_i[gx][gy];
        end
    end

    always_comb begin
        rate_sel = 8'd136;
        sfx_sel  = 8'h06;
        case (mode_i)
            3'd0: rate_sel = 8'd144;
            3'd1: rate_sel = 8'd136;
            3'd2: rate_sel = 8'd104;
            3'd3: rate_sel = 8'd72;
            3'd4: begin rate_sel = 8'd168; sfx_sel = 8'h1F; end
            3'd5: begin rate_sel = 8'd136; sfx_sel = 8'h1F; end
            default: ;
        endcase
    end

    always_comb begin
        n_bytes = '0;
        for (int k = 0; k < KEEP_W; k++) begin
            n_bytes = n_bytes + {7'b0, t_keep_i[k]};
        end
        room   = rate - byte_cnt;
        n_take = (n_bytes > room) ? room : n_bytes;
        data_kept = '0;
        data_take = '0;
        for (int k = 0; k < KEEP_W; k++) begin
            if (t_keep_i[k]) begin
                data_kept[8*k +: 8] = t_data_i[8*k +: 8];
            end
            if (t_keep_i[k] && (8'(k) < n_take)) begin
                data_take[8*k +: 8] = t_data_i[8*k +: 8];
            end
        end
    end

    assign rate_m1    = rate - 8'd1;
    assign carry_next = data_kept >> {room, 3'b000};
    assign beat_vec   = RW'(data_take) << {byte_cnt, 3'b000};
    assign carry_vec  = RW'(carry);
    assign pad_vec    = (RW'(suffix) << {byte_cnt, 3'b000}) ^ (RW'(8'h80) << {rate_m1, 3'b000});

    assign t_ready_o     = (fsm == S_ABSORB) && !carry_valid;
    assign beat          = t_valid_i && t_ready_o;
    assign busy_o        = (fsm != S_IDLE) && (fsm != S_DONE);
    assign absorb_done_o = (fsm == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm          <= S_IDLE;
            st           <= '0;
            byte_cnt     <= '0;
            rate         <= '0;
            suffix       <= '0;
            carry        <= '0;
            carry_len    <= '0;
            carry_valid  <= 1'b0;
            carry_last   <= 1'b0;
            pad_pending  <= 1'b0;
            perm_start_o <= 1'b0;
        end else begin
            perm_start_o <= 1'b0;
            case (fsm)
                S_IDLE, S_DONE: begin
                    if (start_i && (mode_i <= 3'd5)) begin
                        rate        <= rate_sel;
                        suffix      <= sfx_sel;
                        st          <= '0;
                        byte_cnt    <= '0;
                        carry_valid <= 1'b0;
                        carry_last  <= 1'b0;
                        pad_pending <= 1'b0;
                        fsm         <= S_ABSORB;
                    end
                end
                S_ABSORB: begin
                    if (carry_valid) begin
                        // Overflow from the previous block lands at byte 0; no beat this cycle.
                        st          <= st ^ {256'b0, carry_vec};
                        byte_cnt    <= carry_len;
                        carry_valid <= 1'b0;
                        if (carry_last) begin
                            fsm <= S_PAD;
                        end
                    end else if (beat) begin
                        st <= st ^ {256'b0, beat_vec};
                        if (n_bytes < room) begin
                            byte_cnt <= byte_cnt + n_bytes;
                            if (t_last_i) begin
                                fsm <= S_PAD;
                            end
                        end else begin
                            pad_pending <= (n_bytes == room) && t_last_i;
                            if (n_bytes > room) begin
                                carry       <= carry_next;
                                carry_len   <= n_bytes - room;
                                carry_valid <= 1'b1;
                                carry_last  <= t_last_i;
                            end
                            fsm          <= S_PERM_WAIT;
                            perm_start_o <= 1'b1;
                        end
                    end
                end
                S_PERM_WAIT: begin
                    if (perm_done_i) begin
                        st       <= perm_flat;
                        byte_cnt <= '0;
                        if (pad_pending) begin
                            pad_pending <= 1'b0;
                            fsm         <= S_PAD;
                        end else begin
                            fsm <= S_ABSORB;
                        end
                    end
                end
                S_PAD: begin
                    st           <= st ^ {256'b0, pad_vec};
                    fsm          <= S_FINAL_WAIT;
                    perm_start_o <= 1'b1;
                end
                S_FINAL_WAIT: begin
                    if (perm_done_i) begin
                        st  <= perm_flat;
                        fsm <= S_DONE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_absorb_stream.sv
// tb/tb_absorb_stream.sv - self-checking bench for absorb_stream against a sponge-level reference model
module tb_absorb_stream;

    localparam int DW = 256;
    localparam int KW = DW / 8;

    typedef logic [4:0][4:0][63:0] st_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [2:0]    mode_i;
    logic [DW-1:0] t_data_i;
    logic [KW-1:0] t_keep_i;
    logic          t_valid_i;
    logic          t_last_i;
    logic          t_ready_o;
    logic          perm_start_o;
    logic          perm_done_i;
    st_t           perm_state_i;
    st_t           state_o;
    logic          busy_o;
    logic          absorb_done_o;

    int checks = 0;
    int failures = 0;

    logic [7:0] msg_q[$];
    st_t        exp_snap[$];
    st_t        exp_final;
    st_t        snaps[$];

    always #5 clk = ~clk;

    absorb_stream #(.DWIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .t_data_i     (t_data_i),
        .t_keep_i     (t_keep_i),
        .t_valid_i    (t_valid_i),
        .t_last_i     (t_last_i),
        .t_ready_o    (t_ready_o),
        .perm_start_o (perm_start_o),
        .perm_done_i  (perm_done_i),
        .perm_state_i (perm_state_i),
        .state_o      (state_o),
        .busy_o       (busy_o),
        .absorb_done_o(absorb_done_o)
    );

    // Stand-in permutation: any deterministic mixing lets the bench tell blocks apart.
    function automatic st_t fperm(input st_t s);
        st_t r;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                r[x][y] = {s[(x+1)%5][y][62:0], s[(x+1)%5][y][63]} ^ s[x][(y+1)%5]
                          ^ (64'h0123456789ABCDEF + 64'(x*5+y));
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input st_t s, input int b);
        int l;
        l = b / 8;
        return s[l%5][l/5][(b%8)*8 +: 8];
    endfunction

    function automatic int diff_lane(input st_t a, input st_t b);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                if (a[x][y] !== b[x][y]) return x*5 + y;
        return 0;
    endfunction

    function automatic int rate_of(input int mode);
        case (mode)
            0: return 144;
            1: return 136;
            2: return 104;
            3: return 72;
            4: return 168;
            default: return 136;
        endcase
    endfunction

    // Sponge reference: pad the whole message, then absorb it block by block.
    task automatic model(input int mode);
        logic [7:0] p[$];
        st_t s;
        int rate;
        int l;
        rate = rate_of(mode);
        p = msg_q;
        p.push_back((mode >= 4) ? 8'h1F : 8'h06);
        while (p.size() % rate != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] ^ 8'h80;
        s = '0;
        exp_snap.delete();
        for (int blk = 0; blk < p.size() / rate; blk++) begin
            for (int i = 0; i < rate; i++) begin
                l = i / 8;
                s[l%5][l/5][(i%8)*8 +: 8] = s[l%5][l/5][(i%8)*8 +: 8] ^ p[blk*rate + i];
            end
            exp_snap.push_back(s);
            s = fperm(s);
        end
        exp_final = s;
    endtask

    task automatic fill_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_msg(input int mode, input bit rnd_valid);
        int  bsz[$];
        int  rem, bi, pos, pend, fill, room, n, rate, ln;
        bit  done_seen, carry_pend, drain_next, will_acc;
        st_t pstate;
        model(mode);
        rate = rate_of(mode);
        rem = msg_q.size();
        while (rem > KW) begin bsz.push_back(KW); rem -= KW; end
        bsz.push_back(rem);
        snaps.delete();
        bi = 0; pos = 0; pend = -1; fill = 0;
        done_seen = 0; carry_pend = 0; drain_next = 0;
        pstate = '0;
        @(negedge clk);
        t_valid_i = 0; perm_done_i = 0; start_i = 1; mode_i = 3'(mode);
        @(posedge clk);
        #1 start_i = 0;
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            @(negedge clk);
            perm_done_i = 0;
            if (drain_next) begin
                checks++;
                if (t_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL carry_drain_ready: t_ready_o=%b expected 0", t_ready_o);
                end
                drain_next = 0;
            end
            if (pend >= 0 || perm_start_o === 1'b1) begin
                checks++;
                if (t_ready_o !== 1'b0) begin
                    failures++;
                    $display("FAIL perm_wait_ready: t_ready_o=%b expected 0", t_ready_o);
                end
            end
            if (pend == 0) begin
                perm_done_i = 1; perm_state_i = pstate; pend = -1;
                drain_next = carry_pend; carry_pend = 0;
            end else if (pend > 0) begin
                pend--;
            end
            if (perm_start_o === 1'b1) begin
                checks++;
                if (snaps.size() >= exp_snap.size()) begin
                    failures++;
                    $display("FAIL perm_count: pulse %0d seen, expected only %0d", snaps.size() + 1, exp_snap.size());
                end else if (state_o !== exp_snap[snaps.size()]) begin
                    failures++;
                    ln = diff_lane(state_o, exp_snap[snaps.size()]);
                    $display("FAIL pre_perm_state[%0d]: lane x%0d y%0d got %h expected %h", snaps.size(),
                             ln / 5, ln % 5, state_o[ln/5][ln%5], exp_snap[snaps.size()][ln/5][ln%5]);
                end
                snaps.push_back(state_o);
                pstate = fperm(state_o);
                pend = $urandom_range(0, 3);
            end
            if (absorb_done_o === 1'b1) begin
                done_seen = 1;
                t_valid_i = 0;
            end else begin
                if (bi < bsz.size() && (!rnd_valid || $urandom_range(0, 2) != 0)) begin
                    n = bsz[bi];
                    t_valid_i = 1;
                    t_last_i = (bi == bsz.size() - 1);
                    for (int k = 0; k < KW; k++) begin
                        t_keep_i[k] = (k < n);
                        if (k < n) t_data_i[8*k +: 8] = msg_q[pos + k];
                        else       t_data_i[8*k +: 8] = 8'($urandom_range(0, 255));
                    end
                end else begin
                    t_valid_i = 0; t_last_i = 0; t_keep_i = KW'($urandom);
                end
                will_acc = t_valid_i && (t_ready_o === 1'b1);
                @(posedge clk);
                if (will_acc) begin
                    n = bsz[bi];
                    room = rate - fill;
                    if (n > room) begin carry_pend = 1; fill = n - room; end
                    else if (n == room) fill = 0;
                    else fill += n;
                    pos += n;
                    bi++;
                end
            end
        end
        t_valid_i = 0; t_last_i = 0;
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL done_timeout: absorb_done_o never rose (mode %0d len %0d)", mode, msg_q.size());
        end
        checks++;
        if (state_o !== exp_final) begin
            failures++;
            ln = diff_lane(state_o, exp_final);
            $display("FAIL final_state: lane x%0d y%0d got %h expected %h", ln / 5, ln % 5,
                     state_o[ln/5][ln%5], exp_final[ln/5][ln%5]);
        end
        checks++;
        if (snaps.size() != exp_snap.size()) begin
            failures++;
            $display("FAIL perm_total: got %0d expected %0d", snaps.size(), exp_snap.size());
        end
        checks++;
        if (bi != bsz.size() || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL beats_busy: beats %0d/%0d busy_o=%b expected all beats and busy 0", bi, bsz.size(), busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; start_i = 0; mode_i = 0; t_valid_i = 0; t_last_i = 0;
        t_keep_i = '0; t_data_i = '0; perm_done_i = 0; perm_state_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({t_ready_o, perm_start_o, busy_o, absorb_done_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: ready/start/busy/done=%b expected 0000",
                     {t_ready_o, perm_start_o, busy_o, absorb_done_o});
        end
        checks++;
        if (state_o !== '0) begin
            failures++;
            $display("FAIL reset_state: lane x0 y0 got %h expected 0", state_o[0][0]);
        end
        @(negedge clk);
        rst_n = 1; start_i = 1; mode_i = 3'd6;
        @(posedge clk);
        #1 start_i = 0;
        checks++;
        if (busy_o !== 1'b0 || t_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL bad_mode_ignored: busy_o=%b t_ready_o=%b expected 0 0", busy_o, t_ready_o);
        end
    endtask

    task automatic test_empty_sha3_256();
        fill_msg(0);
        run_msg(1, 0);
        checks++;
        if (snaps.size() != 1) begin
            failures++;
            $display("FAIL empty_perm_count: got %0d expected 1", snaps.size());
        end else if (snaps[0][0][0] !== 64'h06 || snaps[0][1][3] !== 64'h8000000000000000) begin
            failures++;
            $display("FAIL empty_pad: lane00 %h lane13 %h expected 6 and 8000000000000000",
                     snaps[0][0][0], snaps[0][1][3]);
        end
    endtask

    task automatic test_sha3_512_carry();
        st_t d;
        logic [7:0] e;
        int bad;
        fill_msg(96);
        run_msg(3, 0);
        checks++;
        if (snaps.size() != 2) begin
            failures++;
            $display("FAIL carry_perm_count: got %0d expected 2", snaps.size());
        end else begin
            d = snaps[1] ^ fperm(snaps[0]);
            bad = -1;
            for (int b = 0; b < 200; b++) begin
                if (b < 24)       e = msg_q[72 + b];
                else if (b == 24) e = 8'h06;
                else if (b == 71) e = 8'h80;
                else              e = 8'h00;
                if (bad < 0 && get_byte(d, b) !== e) bad = b;
            end
            if (bad >= 0) begin
                failures++;
                $display("FAIL carry_block: first bad byte %0d got %h", bad, get_byte(d, bad));
            end
        end
    endtask

    task automatic test_sha3_512_exact();
        st_t d;
        fill_msg(72);
        run_msg(3, 0);
        checks++;
        if (snaps.size() != 2) begin
            failures++;
            $display("FAIL exact_perm_count: got %0d expected 2", snaps.size());
        end else begin
            d = snaps[1] ^ fperm(snaps[0]);
            if (d[0][0] !== 64'h06 || d[3][1] !== 64'h8000000000000000) begin
                failures++;
                $display("FAIL exact_pad_block: lane00 %h lane31 %h expected 6 and 8000000000000000",
                         d[0][0], d[3][1]);
            end
        end
    endtask

    task automatic test_shake128_167();
        fill_msg(167);
        run_msg(4, 0);
        checks++;
        if (snaps.size() != 1) begin
            failures++;
            $display("FAIL shake_perm_count: got %0d expected 1", snaps.size());
        end else if (snaps[0][0][4][63:56] !== 8'h9F) begin
            failures++;
            $display("FAIL shake_shared_pad: got %h expected 9f", snaps[0][0][4][63:56]);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 6; i++) begin
            fill_msg($urandom_range(0, 350));
            run_msg($urandom_range(0, 5), 1);
        end
    endtask

    task automatic test_back_to_back();
        int m;
        for (int i = 0; i < 3; i++) begin
            m = $urandom_range(0, 5);
            fill_msg(rate_of(m) * (i + 1) + i - 1);
            run_msg(m, 0);
        end
    endtask

    task automatic test_reset_mid_perm();
        bit seen;
        @(negedge clk);
        start_i = 1; mode_i = 3'd1;
        @(posedge clk);
        #1 start_i = 0;
        seen = 0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            if (perm_start_o === 1'b1) seen = 1;
            else begin
                t_valid_i = 1; t_last_i = 0; t_keep_i = '1;
                for (int k = 0; k < DW / 32; k++) t_data_i[32*k +: 32] = $urandom;
                @(posedge clk);
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_perm_start: perm_start_o=%b never seen", perm_start_o);
        end
        t_valid_i = 0;
        rst_n = 0;
        @(posedge clk);
        #1;
        checks++;
        if ({t_ready_o, perm_start_o, busy_o, absorb_done_o} !== 4'b0000 || state_o !== '0) begin
            failures++;
            $display("FAIL mid_perm_reset: ready/start/busy/done=%b lane00 %h expected all 0",
                     {t_ready_o, perm_start_o, busy_o, absorb_done_o}, state_o[0][0]);
        end
        @(negedge clk);
        rst_n = 1; perm_done_i = 1;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) perm_state_i[x][y] = {$urandom, $urandom};
        @(posedge clk);
        #1 perm_done_i = 0;
        checks++;
        if (busy_o !== 1'b0 || absorb_done_o !== 1'b0 || state_o !== '0) begin
            failures++;
            $display("FAIL stray_done: busy_o=%b absorb_done_o=%b lane00 %h expected 0 0 0",
                     busy_o, absorb_done_o, state_o[0][0]);
        end
        fill_msg(200);
        run_msg(1, 0);
    endtask

    initial begin
        test_reset();
        test_empty_sha3_256();
        test_sha3_512_carry();
        test_sha3_512_exact();
        test_shake128_167();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_perm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
